fir_filter_axil_slave: RTL and testbench

AXI4-Lite responder (slave) register file for the FIR filter IP; it answers the master VIP used in the IP's BFM bench. It holds four read/write 32-bit registers, pushes input samples to the FIR core, and captures FIR results into a read-only result register with a sticky ready flag. It sits between the AXI interconnect port and the FIR datapath inside the IP top.

---
 rtl/fir_filter_axil_slave.sv | 170 +++++++++++++++++
 tb/tb_fir_filter_axil_slave.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_axil_slave.sv
`timescale 1ns/1ps
// AXI4-Lite register file for the FIR IP: four RW registers, sample push to the core,
// and a read-only result register with a sticky ready flag cleared by reading it.
module fir_filter_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            fir_enable,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   fir_sample,
    output logic                            fir_sample_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   fir_result,
    input  logic                            fir_result_valid
);
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;

    wstate_t                         r_wstate;
    rstate_t                         r_rstate;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_regs [0:3];
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_result;
    logic                            r_result_ready;
    logic                            r_awready;
    logic                            r_wready;
    logic                            r_bvalid;
    logic                            r_arready;
    logic                            r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
    logic                            r_sample_valid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_rdata_mux;
    logic [2:0]                      w_waddr;
    logic [2:0]                      w_raddr;
    logic                            w_unused_ok;

    assign w_waddr     = S_AXI_AWADDR[4:2];
    assign w_raddr     = S_AXI_ARADDR[4:2];
    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_rdata_mux = '0;
        case (w_raddr)
            3'd0:    w_rdata_mux = r_regs[0];
            3'd1:    w_rdata_mux = r_regs[1];
            3'd2:    w_rdata_mux = r_regs[2];
            3'd3:    w_rdata_mux = r_regs[3];
            3'd4:    w_rdata_mux = r_result;
            3'd5:    w_rdata_mux = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, r_result_ready};
            default: w_rdata_mux = '0;
        endcase
    end

    // Write path: both AW and W must be valid together; commit happens on the ACK edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate       <= W_IDLE;
            r_awready      <= 1'b0;
            r_wready       <= 1'b0;
            r_bvalid       <= 1'b0;
            r_sample_valid <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid) begin
                        r_wstate  <= W_ACK;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_ACK: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_wstate  <= W_RESP;
                    if (!w_waddr[2]) begin
                        for (int b = 0; b < NB; b++) begin
                            if (S_AXI_WSTRB[b])
                                r_regs[w_waddr[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                        end
                    end
                    // Sample push fires even when no byte lane is enabled.
                    if (w_waddr == 3'd1) r_sample_valid <= 1'b1;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read path plus result capture; a new result beats the read-side clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate       <= R_IDLE;
            r_arready      <= 1'b0;
            r_rvalid       <= 1'b0;
            r_rdata        <= '0;
            r_result       <= '0;
            r_result_ready <= 1'b0;
        end else begin
            if (fir_result_valid) begin
                r_result       <= fir_result;
                r_result_ready <= 1'b1;
            end else if (r_rstate == R_ACK && w_raddr == 3'd4) begin
                r_result_ready <= 1'b0;
            end
            case (r_rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID && !r_rvalid) begin
                        r_rstate  <= R_ACK;
                        r_arready <= 1'b1;
                    end
                end
                R_ACK: begin
                    r_arready <= 1'b0;
                    r_rdata   <= w_rdata_mux;
                    r_rvalid  <= 1'b1;
                    r_rstate  <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY    = r_awready;
    assign S_AXI_WREADY     = r_wready;
    assign S_AXI_BVALID     = r_bvalid;
    assign S_AXI_BRESP      = 2'b00;
    assign S_AXI_ARREADY    = r_arready;
    assign S_AXI_RVALID     = r_rvalid;
    assign S_AXI_RDATA      = r_rdata;
    assign S_AXI_RRESP      = 2'b00;
    assign fir_enable       = r_regs[0][0];
    assign fir_sample       = r_regs[1];
    assign fir_sample_valid = r_sample_valid;

endmodule

// File: tb/tb_fir_filter_axil_slave.sv
`timescale 1ns/1ps
// Directed bench for fir_filter_axil_slave: register access, strobes, sample pulse,
// result capture/clear, channel skew with back-pressure, and asynchronous reset.
module tb_fir_filter_axil_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        fir_enable;
    logic [31:0] fir_sample;
    logic        fir_sample_valid;
    logic [31:0] fir_result = '0;
    logic        fir_result_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    fir_filter_axil_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .fir_enable(fir_enable), .fir_sample(fir_sample), .fir_sample_valid(fir_sample_valid),
        .fir_result(fir_result), .fir_result_valid(fir_result_valid)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_sig(input string name, ref logic sig);
        int n = 0;
        while (sig !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sig !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout got=%b want=1", name, sig);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        wait_sig("awready", S_AXI_AWREADY);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        wait_sig("bvalid", S_AXI_BVALID);
        checks++;
        if (S_AXI_BRESP !== 2'b00) begin
            errors++;
            $display("FAIL bresp addr=%h got=%b want=00", a, S_AXI_BRESP);
        end
        tick();
        S_AXI_BREADY = 1'b0;
        $display("write addr=%h data=%h strb=%b", a, d, s);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        wait_sig("arready", S_AXI_ARREADY);
        tick();
        S_AXI_ARVALID = 1'b0;
        wait_sig("rvalid", S_AXI_RVALID);
        d = S_AXI_RDATA; r = S_AXI_RRESP;
        tick();
        S_AXI_RREADY = 1'b0;
        $display("read  addr=%h data=%h resp=%b", a, d, r);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        ARESETN = 1'b0;
        tick(); tick();
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
             fir_sample_valid, fir_enable} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=0000000", {S_AXI_AWREADY, S_AXI_WREADY,
                     S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, fir_sample_valid, fir_enable});
        end
        checks++;
        if ({S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP, fir_sample} !== 68'h0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h bresp=%b rresp=%b sample=%h want all 0",
                     S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP, fir_sample);
        end
        ARESETN = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            axi_read(5'(i * 4), d, r);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h want=00000000", i, d);
            end
        end
    endtask

    task automatic test_rw_regs();
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 4; i++) axi_write(5'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, r);
            checks++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                errors++;
                $display("FAIL rw_reg%0d got=%h/%b want=%h/00", i, d, r, 32'(i + 1));
            end
        end
        checks++;
        if (fir_enable !== 1'b1) begin
            errors++;
            $display("FAIL fir_enable got=%b want=1", fir_enable);
        end
        // RO and unused addresses swallow writes
        axi_write(5'h10, 32'hFFFF_FFFF, 4'hF);
        axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL ro_result_write got=%h want=00000000", d);
        end
        axi_read(5'h1C, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unused_1c got=%h want=00000000", d);
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  strbs [2] = '{4'b0101, 4'b0100};
        logic [31:0] exps  [2] = '{32'h11BB_33DD, 32'h11BB_3344};
        for (int i = 0; i < 2; i++) begin
            axi_write(5'h08, 32'h1122_3344, 4'hF);
            axi_write(5'h08, 32'hAABB_CCDD, strbs[i]);
            axi_read(5'h08, d, r);
            checks++;
            if (d !== exps[i]) begin
                errors++;
                $display("FAIL wstrb_%b got=%h want=%h", strbs[i], d, exps[i]);
            end
        end
    endtask

    task automatic test_sample();
        logic [31:0] datas [2] = '{32'h5, 32'h99};
        logic [3:0]  strbs [2] = '{4'hF, 4'h0};
        for (int i = 0; i < 2; i++) begin
            S_AXI_AWADDR = 5'h04; S_AXI_WDATA = datas[i]; S_AXI_WSTRB = strbs[i];
            S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
            wait_sig("sample_awready", S_AXI_AWREADY);
            checks++;
            if (fir_sample_valid !== 1'b0) begin
                errors++;
                $display("FAIL sample_valid_early%0d got=%b want=0", i, fir_sample_valid);
            end
            tick();
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            checks++;
            if (fir_sample_valid !== 1'b1 || fir_sample !== 32'h5) begin
                errors++;
                $display("FAIL sample_pulse%0d got=%b/%h want=1/00000005", i, fir_sample_valid, fir_sample);
            end
            tick();
            S_AXI_BREADY = 1'b0;
            checks++;
            if (fir_sample_valid !== 1'b0) begin
                errors++;
                $display("FAIL sample_valid_width%0d got=%b want=0", i, fir_sample_valid);
            end
            $display("sample write data=%h strb=%b fir_sample=%h", datas[i], strbs[i], fir_sample);
        end
    endtask

    task automatic test_result();
        logic [31:0] d;
        logic [1:0]  r;
        fir_result = 32'hDEAD_0001; fir_result_valid = 1'b1;
        tick();
        fir_result_valid = 1'b0;
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL status_set got=%h want=00000001", d); end
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'hDEAD_0001) begin errors++; $display("FAIL result got=%h want=dead0001", d); end
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL status_clear got=%h want=00000000", d); end
        // New result arriving on the clearing AR handshake: set wins, read sees old value
        fir_result = 32'hDEAD_0002; fir_result_valid = 1'b1;
        tick();
        fir_result_valid = 1'b0;
        S_AXI_ARADDR = 5'h10; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        wait_sig("res_arready", S_AXI_ARREADY);
        fir_result = 32'h1234_5678; fir_result_valid = 1'b1;
        tick();
        fir_result_valid = 1'b0; S_AXI_ARVALID = 1'b0;
        checks++;
        if (S_AXI_RDATA !== 32'hDEAD_0002) begin
            errors++;
            $display("FAIL collide_rdata got=%h want=dead0002", S_AXI_RDATA);
        end
        tick();
        S_AXI_RREADY = 1'b0;
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL collide_status got=%h want=00000001", d); end
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h1234_5678) begin errors++; $display("FAIL collide_result got=%h want=12345678", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        int early = 0;
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) early++;
            tick();
        end
        checks++;
        if (early != 0) begin errors++; $display("FAIL aw_alone_accepted got=%0d want=0", early); end
        S_AXI_WVALID = 1'b1;
        wait_sig("skew_awready", S_AXI_AWREADY);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (S_AXI_BVALID !== 1'b1) begin
                errors++;
                $display("FAIL bvalid_hold%0d got=%b want=1", i, S_AXI_BVALID);
            end
            tick();
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL bvalid_drop got=%b want=0", S_AXI_BVALID); end
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL skew_readback got=%h want=cafef00d", d); end
    endtask

    task automatic test_reset_midread();
        logic [31:0] d;
        logic [1:0]  r;
        S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        wait_sig("mr_arready", S_AXI_ARREADY);
        tick();
        S_AXI_ARVALID = 1'b0;
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if (S_AXI_RVALID !== 1'b0 || fir_enable !== 1'b0 || fir_sample !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got rvalid=%b en=%b sample=%h want 0/0/0",
                     S_AXI_RVALID, fir_enable, fir_sample);
        end
        tick();
        ARESETN = 1'b1;
        S_AXI_RREADY = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL stale_rvalid got=%b want=0", S_AXI_RVALID); end
        axi_read(5'h00, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_reset_reg0 got=%h want=00000000", d); end
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_reset_reg3 got=%h want=00000000", d); end
    endtask

    initial begin
        test_reset();
        test_rw_regs();
        test_wstrb();
        test_sample();
        test_result();
        test_back_to_back();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
